// File: rtl/noc_crossbar_if.sv
// Shared NoC router types plus the input-block and switch-allocator bundles
// that feed the crossbar.
package noc_params;
  localparam int PORT_NUM       = 5;
  localparam int PORT_SIZE      = $clog2(PORT_NUM);
  localparam int VC_NUM         = 2;
  localparam int VC_SIZE        = $clog2(VC_NUM);
  localparam int FLIT_DATA_SIZE = 16;

  typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3} flit_label_t;

  typedef struct packed {
    flit_label_t               flit_label;
    logic [VC_SIZE-1:0]        vc_id;
    logic [FLIT_DATA_SIZE-1:0] data;
  } flit_t;
endpackage

interface input_block2crossbar;
  import noc_params::*;
  flit_t [PORT_NUM-1:0] flit;

  modport input_block (output flit);
  modport crossbar    (input  flit);
endinterface

interface switch_allocator2crossbar;
  import noc_params::*;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] input_vc_sel;

  modport switch_allocator (output input_vc_sel);
  modport crossbar         (input  input_vc_sel);
endinterface

// File: rtl/noc_crossbar.sv
// PORT_NUM x PORT_NUM flit switch: output i carries the input named by input_vc_sel[i].
// Define CROSSBAR_OUT_REG_EN to register data_o (1-cycle latency, synchronous reset to zero).
module noc_crossbar
  import noc_params::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input_block2crossbar.crossbar        ib_if,
  switch_allocator2crossbar.crossbar   sa_if,
  output flit_t [PORT_NUM-1:0]         data_o
);

  localparam int SEL_NUM = 2 ** PORT_SIZE;

  // Pad the source table to the full select range so unused codes read as a zero
  // flit while a plain index still propagates an unknown select.
  flit_t [SEL_NUM-1:0]  ext_s;
  flit_t [PORT_NUM-1:0] mux_s;

  for (genvar g = 0; g < PORT_NUM; g++) begin : g_src
    assign ext_s[g] = ib_if.flit[g];
  end

  for (genvar g = PORT_NUM; g < SEL_NUM; g++) begin : g_pad
    assign ext_s[g] = '0;
  end

  for (genvar g = 0; g < PORT_NUM; g++) begin : g_mux
    assign mux_s[g] = ext_s[sa_if.input_vc_sel[g]];
  end

`ifdef CROSSBAR_OUT_REG_EN
  flit_t [PORT_NUM-1:0] data_r;

  // Output stage: reset wins over the flit in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= '0;
    end else begin
      data_r <= mux_s;
    end
  end

  assign data_o = data_r;
`else
  logic unused_s;

  assign unused_s = clk ^ rst;
  assign data_o   = mux_s;
`endif

endmodule

// File: tb/tb_noc_crossbar.sv
// Directed bench for noc_crossbar: a per-cycle model compare plus literal checks
// for identity, broadcast, out-of-range select and reset behaviour.
module tb_noc_crossbar;
  import noc_params::*;

`ifdef CROSSBAR_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  flit_t [PORT_NUM-1:0]               flit_v;
  logic [PORT_NUM-1:0][PORT_SIZE-1:0] sel_v;
  flit_t [PORT_NUM-1:0]               data_o;
  flit_t [PORT_NUM-1:0]               exp_r;
  logic  check_en = 1'b0;
  int    checks = 0;
  int    errors = 0;

  input_block2crossbar      ib ();
  switch_allocator2crossbar sa ();

  assign ib.flit         = flit_v;
  assign sa.input_vc_sel = sel_v;

  noc_crossbar dut (
    .clk    (clk),
    .rst    (rst),
    .ib_if  (ib),
    .sa_if  (sa),
    .data_o (data_o)
  );

  always #5 clk = ~clk;

  // Model: output i is the flit of the named input, or zero for a code beyond the ports.
  function automatic flit_t model(input int i);
    int s;
    s = int'(sel_v[i]);
    if (s < PORT_NUM) return flit_v[s];
    else return '0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < PORT_NUM; i++) exp_r[i] <= rst ? flit_t'('0) : model(i);
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < PORT_NUM; i++) begin
        flit_t e;
        e = (LAT == 1) ? exp_r[i] : model(i);
        checks++;
        if (data_o[i] !== e) begin
          errors++;
          $display("FAIL model_out%0d: got %h want %h at %0t", i, data_o[i], e, $time);
        end
      end
    end
  end

  task automatic chk(input string nm, input flit_t act, input flit_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic flit_t mk(input flit_label_t l, input logic [VC_SIZE-1:0] v,
                               input logic [FLIT_DATA_SIZE-1:0] d);
    flit_t f;
    f.flit_label = l;
    f.vc_id      = v;
    f.data       = d;
    return f;
  endfunction

  // Inputs change just after a posedge; results are read at the negedge once latency has elapsed.
  task automatic settle();
    repeat (LAT) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic launch();
    @(posedge clk);
    #1;
  endtask

  initial begin
    flit_t hot;
    flit_t bc;
    hot = mk(HEAD, 1'b1, 16'hFFFF);
    bc  = mk(TAIL, 1'b0, 16'hA5A5);
    flit_v = '0;
    sel_v  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_en = 1'b1;

    // Rotation sweep with a single known input among unknowns.
    for (int k = 0; k < PORT_NUM; k++) begin
      for (int j = 0; j < PORT_NUM; j++) begin
        int hit;
        for (int m = 0; m < PORT_NUM; m++) flit_v[m] = 'x;
        flit_v[j] = hot;
        for (int i = 0; i < PORT_NUM; i++) sel_v[i] = 3'((i + k) % PORT_NUM);
        settle();
        hit = (j - k + PORT_NUM) % PORT_NUM;
        chk($sformatf("rot_k%0d_j%0d", k, j), data_o[hit], mk(HEAD, 1'b1, 16'hFFFF));
        launch();
      end
    end

    // Identity.
    for (int i = 0; i < PORT_NUM; i++) begin
      flit_v[i] = mk(BODY, 1'b0, 16'(16'h0010 + i));
      sel_v[i]  = 3'(i);
    end
    settle();
    for (int i = 0; i < PORT_NUM; i++)
      chk($sformatf("ident_%0d", i), data_o[i], mk(BODY, 1'b0, 16'(16'h0010 + i)));
    launch();

    // Broadcast of input 3.
    flit_v[3] = bc;
    for (int i = 0; i < PORT_NUM; i++) sel_v[i] = 3'd3;
    settle();
    for (int i = 0; i < PORT_NUM; i++)
      chk($sformatf("bcast_%0d", i), data_o[i], mk(TAIL, 1'b0, 16'hA5A5));
    launch();

    // Out-of-range select on output 2 only.
    flit_v[3] = mk(BODY, 1'b0, 16'h0013);
    for (int i = 0; i < PORT_NUM; i++) sel_v[i] = 3'(i);
    sel_v[2] = 3'd7;
    settle();
    chk("oor_2", data_o[2], flit_t'('0));
    for (int i = 0; i < PORT_NUM; i++)
      if (i != 2) chk($sformatf("oor_other_%0d", i), data_o[i], mk(BODY, 1'b0, 16'(16'h0010 + i)));
    launch();

    // Reset pulse: clears the registered outputs, no effect when combinational.
    sel_v[2] = 3'd2;
    settle();
    launch();
    rst = 1'b1;
    settle();
    chk("rst_out0", data_o[0], (LAT == 1) ? flit_t'('0) : mk(BODY, 1'b0, 16'h0010));
    chk("rst_out4", data_o[4], (LAT == 1) ? flit_t'('0) : mk(BODY, 1'b0, 16'h0014));
    launch();
    rst = 1'b0;
    settle();
    chk("post_rst_out0", data_o[0], mk(BODY, 1'b0, 16'h0010));
    chk("post_rst_out4", data_o[4], mk(BODY, 1'b0, 16'h0014));

    check_en = 1'b0;
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
